bcd_tick_counter: RTL and testbench
===================================

Name: bcd_tick_counter

Overview:
Parametrised seconds-style timebase and multi-digit BCD up/down counter for the DE10-Lite display path. Divides the 10 MHz board clock into a periodic tick and counts ticks in packed BCD, modulo a programmable value. Drives a half-duty heartbeat LED and feeds sevenSeg instances one nibble per digit. Generalises the fixed 2-digit, up-only, modulo-100 counter with direction, load, pause and a registered wrap pulse.

Parameters:
DIGITS, 2, number of BCD digits (1..6)
MODULO, 100, count wraps at MODULO (2..10^DIGITS); legal values 0..MODULO-1
TICK_DIV, 10_000_000, clock cycles per tick (>=2); 1 s at 10 MHz
DIV_W, $clog2(TICK_DIV), prescaler width (derived, not overridden)

Ports:
ADC_CLK_10  in   1           single system clock, all logic on posedge
rst_n       in   1           synchronous reset, active-low
run         in   1           1 = prescaler advances; 0 = pause (prescaler and count hold)
up          in   1           1 = count up, 0 = count down; sampled at tick
load        in   1           synchronous load strobe
load_val    in   4*DIGITS    packed BCD load value, digit 0 in [3:0]
bcd_out     out  4*DIGITS    packed BCD count
tick        out  1           1-cycle pulse, high in the cycle bcd_out first shows the new value
wrap        out  1           1-cycle pulse coincident with tick when count wrapped
led         out  1           heartbeat: high for first TICK_DIV/2 cycles of each period
load_err    out  1           1-cycle pulse: load rejected

Behaviour:
- Reset (rst_n=0 at posedge): prescaler=0, bcd_out=0, tick=0, wrap=0, led=0, load_err=0. Overrides all other inputs, including mid-period.
- Prescaler: counts 0..TICK_DIV-1 while run=1; at TICK_DIV-1 returns to 0 and issues an internal tick. run=0 freezes prescaler; no tick lost or duplicated on resume.
- Count update registered on the prescaler terminal cycle; bcd_out, tick and wrap change together on the following edge (1-cycle latency from terminal count).
- Up: value MODULO-1 -> 0 with wrap=1; otherwise +1 with BCD digit carry (9 -> 0, carry into next digit).
- Down: value 0 -> MODULO-1 with wrap=1; otherwise -1 with BCD borrow (0 -> 9).
- up sampled only on the terminal cycle; direction changes mid-period take effect at next tick.
- Load: load=1 and load_val all-BCD and < MODULO -> bcd_out=load_val next edge, prescaler cleared to 0, no tick/wrap that cycle. Any nibble > 9 or value >= MODULO -> bcd_out and prescaler unchanged, load_err=1 one cycle.
- Priority: rst_n > load > tick. load coincident with terminal count: load wins, the tick is discarded.
- led = run & (prescaler < TICK_DIV/2), registered; odd TICK_DIV gives low half one cycle longer. led=0 while paused.
- No arithmetic on binary; all counting digitwise BCD; bcd_out never holds a non-BCD nibble.

Optional Feature:
LAP_HOLD_EN: adds input lap (1 bit). Defined: lap=1 freezes bcd_out at its current value while the internal count keeps ticking; on lap=0, bcd_out resyncs to the live count the next edge; tick/wrap still follow the internal count. Undefined: no lap port; bcd_out is always the live count.

Decomposition:
- Shared params package: CLK_HZ=10_000_000, default TICK_DIV, BCD digit width constant (4), blank/dash codes used by sevenSeg.
- One sub-module bcd_digit: 4-bit digit with inc/dec enable, carry/borrow in/out, sync load; instantiated DIGITS times via generate. Modulo compare and wrap handled in the parent.

Test Plan:
- TICK_DIV=4, up=1, run=1 from reset: tick every 4 cycles; bcd_out 00,01..09,10 (carry); led high 2 of 4 cycles.
- MODULO=100 at 99, up=1, tick -> bcd_out=00, wrap=1 same cycle as tick; MODULO=60 at 59 -> 00 with wrap.
- Down from 00 with MODULO=60 -> 59, wrap=1; 10 -> 09 (borrow).
- load_val=8'h45 -> bcd_out=45, prescaler=0; load_val=8'h4A or 8'h99 with MODULO=60 -> load_err=1, bcd_out unchanged.
- run=0 for 10 cycles mid-period: bcd_out and led hold (led=0); next tick after exactly remaining period on resume.
- rst_n=0 asserted coincident with load and terminal count -> all outputs 0 next edge; load and tick both ignored.

Source files
------------

// File: rtl/bcd_tick_counter_pkg.sv
// Shared constants for the DE10-Lite BCD timebase and display path.
package bcd_tick_counter_pkg;

    localparam int         CLK_HZ        = 10_000_000;
    localparam int         TICK_DIV_DFLT = CLK_HZ;
    localparam int         BCD_W         = 4;
    localparam int         MAX_DIGITS    = 6;

    // Active-low segment codes {g,f,e,d,c,b,a} consumed by sevenSeg.
    localparam logic [6:0] SEG_BLANK     = 7'h7F;
    localparam logic [6:0] SEG_DASH      = 7'h3F;

    function automatic logic [BCD_W*MAX_DIGITS-1:0] to_bcd(input int v);
        logic [BCD_W*MAX_DIGITS-1:0] r;
        int                          t;
        r = '0;
        t = v;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[BCD_W*i +: BCD_W] = BCD_W'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_tick_counter_digit.sv
// One BCD digit: steps up/down on carry-in, ripples carry/borrow out, sync load.
module bcd_digit
    import bcd_tick_counter_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             up_i,
    input  logic             step_i,
    input  logic             ld_i,
    input  logic [BCD_W-1:0] ld_val_i,
    output logic [BCD_W-1:0] q_o,
    output logic             cout_o
);

    logic [BCD_W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = ld_val_i;
        end else if (step_i) begin
            if (up_i) q_d = (q_q >= 4'd9) ? 4'd0 : q_q + 4'd1;
            else      q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
        end
    end

    assign cout_o = step_i & (up_i ? (q_q >= 4'd9) : (q_q == 4'd0));
    assign q_o    = q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) q_q <= '0;
        else         q_q <= q_d;
    end

endmodule

// File: rtl/bcd_tick_counter.sv
// Tick prescaler plus DIGITS-wide BCD up/down modulo counter with load and heartbeat LED.
// Optional LAP_HOLD_EN adds a lap input that freezes bcd_out while counting continues.
module bcd_tick_counter
    import bcd_tick_counter_pkg::*;
#(
    parameter  int DIGITS   = 2,
    parameter  int MODULO   = 100,
    parameter  int TICK_DIV = TICK_DIV_DFLT,
    localparam int DIV_W    = $clog2(TICK_DIV)
) (
    input  logic                  ADC_CLK_10,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
`ifdef LAP_HOLD_EN
    input  logic                  lap,
`endif
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  tick,
    output logic                  wrap,
    output logic                  led,
    output logic                  load_err
);

    localparam int                      W        = BCD_W * DIGITS;
    localparam logic [BCD_W*MAX_DIGITS-1:0] MAX_FULL = to_bcd(MODULO - 1);
    localparam logic [W-1:0]            MAX_BCD  = MAX_FULL[W-1:0];
    localparam logic [DIV_W-1:0]        TERM     = DIV_W'(TICK_DIV - 1);
    localparam logic [DIV_W-1:0]        HALF     = DIV_W'(TICK_DIV / 2);

    logic [DIV_W-1:0]             div_q, div_d;
    logic                         tick_q, tick_d;
    logic                         wrap_q, wrap_d;
    logic                         led_q, led_d;
    logic                         err_q, err_d;

    logic                         term, all_bcd, load_ok, at_edge, step, do_wrap, dig_ld;
    logic [DIGITS-1:0][BCD_W-1:0] dig, dig_ld_val;
    logic [DIGITS:0]              carry;
    logic [W-1:0]                 live;

    always_comb begin
        all_bcd = 1'b1;
        for (int i = 0; i < DIGITS; i++)
            if (load_val[BCD_W*i +: BCD_W] > 4'd9) all_bcd = 1'b0;
    end

    // With every nibble valid, packed-BCD order matches numeric order.
    assign load_ok = load & all_bcd & (load_val <= MAX_BCD);
    assign term    = run & (div_q == TERM);
    assign live    = dig;
    assign at_edge = up ? (live == MAX_BCD) : (live == '0);
    assign step    = term & ~load;
    assign do_wrap = step & at_edge;
    assign dig_ld  = load_ok | do_wrap;
    assign carry[0] = step & ~at_edge;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign dig_ld_val[g] = load_ok ? load_val[BCD_W*g +: BCD_W]
                                       : (up ? '0 : MAX_BCD[BCD_W*g +: BCD_W]);
        bcd_digit u_dig (
            .clk_i    (ADC_CLK_10),
            .rst_ni   (rst_n),
            .up_i     (up),
            .step_i   (carry[g]),
            .ld_i     (dig_ld),
            .ld_val_i (dig_ld_val[g]),
            .q_o      (dig[g]),
            .cout_o   (carry[g+1])
        );
    end

    always_comb begin
        div_d  = div_q;
        tick_d = 1'b0;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (load) begin
            if (load_ok) div_d = '0;
            else         err_d = 1'b1;
        end else if (term) begin
            div_d  = '0;
            tick_d = 1'b1;
            // Top-digit ripple only occurs alongside at_edge; kept as a backstop.
            wrap_d = at_edge | carry[DIGITS];
        end else if (run) begin
            div_d = div_q + DIV_W'(1);
        end
        led_d = run & (div_d < HALF);
    end

    always_ff @(posedge ADC_CLK_10) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            led_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            led_q  <= led_d;
            err_q  <= err_d;
        end
    end

`ifdef LAP_HOLD_EN
    logic         hold_q;
    logic [W-1:0] frz_q;

    always_ff @(posedge ADC_CLK_10) begin
        if (!rst_n) begin
            hold_q <= 1'b0;
            frz_q  <= '0;
        end else begin
            hold_q <= lap;
            if (!hold_q) frz_q <= live;
        end
    end

    assign bcd_out = hold_q ? frz_q : live;
`else
    assign bcd_out = live;
`endif

    assign tick     = tick_q;
    assign wrap     = wrap_q;
    assign led      = led_q;
    assign load_err = err_q;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench: MODULO=100 and MODULO=60 instances, TICK_DIV=4, shared stimulus.
module tb_bcd_tick_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, run, up, load;
    logic [7:0] load_val;
    logic [7:0] bcd_a, bcd_b;
    logic       tick_a, tick_b, wrap_a, wrap_b, led_a, led_b, err_a, err_b;

    int n_run  = 0;
    int n_fail = 0;

    bcd_tick_counter #(.DIGITS(2), .MODULO(100), .TICK_DIV(4)) u_m100 (
        .ADC_CLK_10(clk), .rst_n(rst_n), .run(run), .up(up), .load(load), .load_val(load_val),
`ifdef LAP_HOLD_EN
        .lap(1'b0),
`endif
        .bcd_out(bcd_a), .tick(tick_a), .wrap(wrap_a), .led(led_a), .load_err(err_a)
    );

    bcd_tick_counter #(.DIGITS(2), .MODULO(60), .TICK_DIV(4)) u_m60 (
        .ADC_CLK_10(clk), .rst_n(rst_n), .run(run), .up(up), .load(load), .load_val(load_val),
`ifdef LAP_HOLD_EN
        .lap(1'b0),
`endif
        .bcd_out(bcd_b), .tick(tick_b), .wrap(wrap_b), .led(led_b), .load_err(err_b)
    );

    typedef struct {
        logic [7:0] val;
        logic [7:0] e100;
        logic       err100;
        logic [7:0] e60;
        logic       err60;
    } ld_vec_t;

    ld_vec_t tbl [8];

    function automatic logic [7:0] b2b(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Pairs are {m100, m60}.
    task automatic chk_st(input string nm, input logic [7:0] e100, input logic [7:0] e60,
                          input logic [1:0] et, input logic [1:0] ew,
                          input logic [1:0] el, input logic [1:0] ee);
        chk({nm, " bcd100"}, 32'(bcd_a), 32'(e100));
        chk({nm, " bcd60"},  32'(bcd_b), 32'(e60));
        chk({nm, " tick"},   32'({tick_a, tick_b}), 32'(et));
        chk({nm, " wrap"},   32'({wrap_a, wrap_b}), 32'(ew));
        chk({nm, " led"},    32'({led_a, led_b}), 32'(el));
        chk({nm, " err"},    32'({err_a, err_b}), 32'(ee));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Run 'steps' edges with run=1 from prescaler value div0; tick expected on the last.
    task automatic run_to_tick(input string nm, input int steps,
                               input logic [7:0] p100, input logic [7:0] p60,
                               input logic [7:0] e100, input logic [7:0] e60,
                               input logic [1:0] ew, input int div0);
        for (int k = 1; k <= steps; k++) begin
            cyc();
            if (k < steps)
                chk_st(nm, p100, p60, 2'b00, 2'b00, (((div0 + k) % 4) < 2) ? 2'b11 : 2'b00, 2'b00);
            else
                chk_st(nm, e100, e60, 2'b11, ew, (((div0 + k) % 4) < 2) ? 2'b11 : 2'b00, 2'b00);
        end
    endtask

    initial begin
        tbl[0] = '{8'h45, 8'h45, 1'b0, 8'h45, 1'b0};
        tbl[1] = '{8'h4A, 8'h45, 1'b1, 8'h45, 1'b1};
        tbl[2] = '{8'h99, 8'h99, 1'b0, 8'h45, 1'b1};
        tbl[3] = '{8'h60, 8'h60, 1'b0, 8'h45, 1'b1};
        tbl[4] = '{8'hA0, 8'h60, 1'b1, 8'h45, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{8'h59, 8'h59, 1'b0, 8'h59, 1'b0};
        tbl[7] = '{8'h99, 8'h99, 1'b0, 8'h59, 1'b1};

        rst_n = 1'b0; run = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;
        cyc(); cyc();
        chk_st("reset", 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00);

        // Free-running up count: tick every 4 edges, carry 09 -> 10.
        rst_n = 1'b1;
        for (int n = 1; n <= 44; n++) begin
            cyc();
            chk_st("count_up", b2b(n / 4), b2b(n / 4), (n % 4 == 0) ? 2'b11 : 2'b00,
                   2'b00, ((n % 4) < 2) ? 2'b11 : 2'b00, 2'b00);
        end

        // Load acceptance/rejection with the prescaler paused.
        run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load = 1'b1; load_val = tbl[i].val;
            cyc();
            chk_st($sformatf("load[%0d]", i), tbl[i].e100, tbl[i].e60, 2'b00, 2'b00,
                   2'b00, {tbl[i].err100, tbl[i].err60});
        end
        load = 1'b0;
        cyc();
        chk_st("load_idle", 8'h99, 8'h59, 2'b00, 2'b00, 2'b00, 2'b00);

        // Up wrap at MODULO-1 for both instances, then down wrap from 00.
        run = 1'b1; up = 1'b1;
        run_to_tick("wrap_up", 4, 8'h99, 8'h59, 8'h00, 8'h00, 2'b11, 0);
        up = 1'b0;
        run_to_tick("wrap_dn", 4, 8'h00, 8'h00, 8'h99, 8'h59, 2'b11, 0);

        // Borrow 10 -> 09; up wiggles mid-period but is low on the terminal cycle.
        load = 1'b1; load_val = 8'h10;
        cyc();
        chk_st("load_run", 8'h10, 8'h10, 2'b00, 2'b00, 2'b11, 2'b00);
        load = 1'b0; up = 1'b1;
        cyc();
        chk_st("dir_mid1", 8'h10, 8'h10, 2'b00, 2'b00, 2'b11, 2'b00);
        cyc();
        chk_st("dir_mid2", 8'h10, 8'h10, 2'b00, 2'b00, 2'b00, 2'b00);
        up = 1'b0;
        run_to_tick("borrow", 2, 8'h10, 8'h10, 8'h09, 8'h09, 2'b00, 2);

        // Pause for 10 cycles at prescaler 1; resume must tick after 3 more edges.
        cyc();
        chk_st("pre_pause", 8'h09, 8'h09, 2'b00, 2'b00, 2'b11, 2'b00);
        run = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk_st("pause", 8'h09, 8'h09, 2'b00, 2'b00, 2'b00, 2'b00);
        end
        run = 1'b1;
        run_to_tick("resume", 3, 8'h09, 8'h09, 8'h08, 8'h08, 2'b00, 1);

        // Load coincident with terminal count: load wins, tick discarded.
        for (int k = 1; k <= 3; k++) begin
            cyc();
            chk_st("pre_ldterm", 8'h08, 8'h08, 2'b00, 2'b00, (k < 2) ? 2'b11 : 2'b00, 2'b00);
        end
        load = 1'b1; load_val = 8'h33;
        cyc();
        chk_st("ld_at_term", 8'h33, 8'h33, 2'b00, 2'b00, 2'b11, 2'b00);
        load = 1'b0;
        run_to_tick("post_ld", 4, 8'h33, 8'h33, 8'h32, 8'h32, 2'b00, 0);

        // Reset coincident with load and terminal count.
        cyc(); cyc(); cyc();
        chk_st("pre_rst", 8'h32, 8'h32, 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b0; load = 1'b1; load_val = 8'h45;
        cyc();
        chk_st("rst_term", 8'h00, 8'h00, 2'b00, 2'b00, 2'b00, 2'b00);
        rst_n = 1'b1; load = 1'b0; up = 1'b1;
        run_to_tick("post_rst", 4, 8'h00, 8'h00, 8'h01, 8'h01, 2'b00, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
